// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave: FSM state encoding,
// frame/data widths, command encodings and bit-counter landmarks.
package spi_pkg;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;

   // Command field rx_data[9:8]
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   // Bit counter value on the edge that captures rx_data[0], and the
   // saturated value meaning "frame complete, ignore further MOSI bits".
   localparam logic [3:0] BIT_CNT_LAST = 4'd8;
   localparam logic [3:0] BIT_CNT_DONE = 4'd9;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

endpackage

// File: rtl/spi_tx_ser.sv
// MISO serializer: latches a read byte on load, then shifts it out
// MSB-first, one bit per edge over the following 8 edges, then returns
// MISO to 0. done stays high until clear so a frame sends its byte once.
// clear has priority over load.
module spi_tx_ser
   import spi_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] tx_data,
   output logic              miso,
   output logic              busy,
   output logic              done
);

   logic [DATA_W-1:0] shreg;
   logic [3:0]        cnt;

   assign busy = (cnt != 4'd0);

   // Latch, shift and done tracking; MISO is registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= 4'd0;
         done  <= 1'b0;
         miso  <= 1'b0;
      end else if (clear) begin
         shreg <= '0;
         cnt   <= 4'd0;
         done  <= 1'b0;
         miso  <= 1'b0;
      end else if (load) begin
         shreg <= tx_data;
         cnt   <= 4'd8;
         miso  <= 1'b0;
      end else if (cnt != 4'd0) begin
         miso  <= shreg[DATA_W-1];
         shreg <= {shreg[DATA_W-2:0], 1'b0};
         cnt   <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            done <= 1'b1;
         end
      end else begin
         miso <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for a RAM stage. Receives 10-bit frames
// (2-bit command + 8-bit address/data) MSB-first on MOSI, strobes them
// out on rx_valid, and for read-data frames returns one byte on MISO.
// Optional: define SPI_FRAME_ERR_EN to add the frame_err output, which
// pulses when SS_n aborts a frame early or cuts a MISO byte short.
module spi_slave
   import spi_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               SS_n,
   input  logic               MOSI,
   output logic               MISO,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
`ifdef SPI_FRAME_ERR_EN
   output logic               frame_err,
`endif
   input  logic [DATA_W-1:0]  tx_data,
   input  logic               tx_valid
);

   state_t     state_q, state_d;
   logic [3:0] bit_cnt;
   logic       rd_addr_seen;
   logic       in_shift;
   logic       frame_done;
   logic       ser_clear;
   logic       ser_load;
   logic       ser_busy;
   logic       ser_done;

   assign in_shift   = (state_q == WRITE) || (state_q == READ_ADD) ||
                       (state_q == READ_DATA);
   assign frame_done = (bit_cnt == BIT_CNT_DONE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and serializer control; SS_n high aborts from any state
   always_comb begin
      state_d   = state_q;
      ser_clear = 1'b1;
      ser_load  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!SS_n) state_d = CHK_CMD;
         end
         CHK_CMD: begin
            if (SS_n)              state_d = IDLE;
            else if (!MOSI)        state_d = WRITE;
            else if (rd_addr_seen) state_d = READ_DATA;
            else                   state_d = READ_ADD;
         end
         WRITE, READ_ADD: begin
            if (SS_n) state_d = IDLE;
         end
         READ_DATA: begin
            if (SS_n) begin
               state_d = IDLE;
            end else begin
               ser_clear = 1'b0;
               ser_load  = frame_done && tx_valid && !ser_busy && !ser_done;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Frame capture, bit counter, rx_valid strobe and read-address tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         bit_cnt      <= 4'd0;
         rd_addr_seen <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (state_q == CHK_CMD && !SS_n) begin
            rx_data <= {MOSI, {(FRAME_W-1){1'b0}}};
            bit_cnt <= 4'd0;
         end else if (in_shift && !SS_n) begin
            if (!frame_done) begin
               rx_data <= {rx_data[FRAME_W-1], rx_data[FRAME_W-3:0], MOSI};
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == BIT_CNT_LAST) begin
                  rx_valid <= 1'b1;
                  if (state_q == READ_ADD)  rd_addr_seen <= 1'b1;
                  if (state_q == READ_DATA) rd_addr_seen <= 1'b0;
               end
            end
         end else begin
            bit_cnt <= 4'd0;
         end
      end
   end

`ifdef SPI_FRAME_ERR_EN
   // Early SS_n release: before the frame completed, or mid MISO byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err <= 1'b0;
      end else begin
         frame_err <= in_shift && SS_n &&
                      (!frame_done || (state_q == READ_DATA && ser_busy));
      end
   end
`endif

   spi_tx_ser u_ser (
      .clk     (clk),
      .rst     (rst),
      .clear   (ser_clear),
      .load    (ser_load),
      .tx_data (tx_data),
      .miso    (MISO),
      .busy    (ser_busy),
      .done    (ser_done)
   );

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock for all state; rst  input  1  asynchronous, active-high reset.
REQ-002 The block SHALL have these further ports: SS_n  input  1  active-low slave select, sampled on clk.
REQ-003 MOSI  input  1  serial data in, sampled on clk rising edge.
REQ-004 MISO  output  1  serial data out, registered.
REQ-005 rx_data  output  10  parallel frame to the RAM stage; [9:8] command, [7:0] address or data.
REQ-006 rx_valid  output  1  one-cycle strobe; rx_data is valid while this is high.
REQ-007 tx_data  input  8  read data returned by the RAM stage.
REQ-008 tx_valid  input  1  tx_data is valid while this is high.

Function
REQ-009 The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA; the state register updates on the clk rising edge.
REQ-010 IDLE SHALL go to CHK_CMD on the first edge at which SS_n=0.
REQ-011 In CHK_CMD, MOSI SHALL be captured into rx_data bit [9]; MOSI=0 goes to WRITE; MOSI=1 goes to READ_ADD if rd_addr_seen=0, otherwise to READ_DATA.
REQ-012 WRITE, READ_ADD and READ_DATA SHALL each shift 9 more MOSI bits MSB-first into rx_data bits [8:0], one bit per edge, under a 4-bit bit counter.
REQ-013 On the edge that captures bit [0], rx_data SHALL hold the full frame and rx_valid SHALL be registered high for exactly one cycle; the frame latency is 11 edges from SS_n falling.
REQ-014 rx_data SHALL hold its value after rx_valid until the next frame's shift begins.
REQ-015 A completed READ_ADD frame SHALL set rd_addr_seen; a completed READ_DATA frame SHALL clear it; a WRITE frame SHALL leave it unchanged.
REQ-016 After rx_valid, WRITE and READ_ADD SHALL remain idle in their state, with MISO=0, until SS_n=1.
REQ-017 After rx_valid, READ_DATA SHALL wait for tx_valid=1, latch tx_data on that edge, and then drive MISO MSB-first over the following 8 edges (one bit per edge).
REQ-018 After the 8th bit, MISO SHALL return to 0; further tx_valid pulses in the same frame SHALL be ignored.
REQ-019 SS_n=1 in any non-IDLE state SHALL force IDLE on the next edge, clear the bit and serializer counters, abort any transfer, and drive MISO=0.
REQ-020 An aborted frame SHALL NOT produce rx_valid and SHALL NOT change rd_addr_seen.
REQ-021 If SS_n rises on the same edge that would capture bit [0], the frame SHALL count as aborted: no rx_valid.
REQ-022 If tx_valid and SS_n=1 coincide, the abort SHALL win and tx_data SHALL NOT be latched.
REQ-023 The bit counter SHALL NOT wrap; a frame SHALL carry at most 10 MOSI bits and excess bits SHALL be ignored.

Reset
REQ-024 rst=1 SHALL asynchronously set: state=IDLE, rx_data=0, rx_valid=0, MISO=0, rd_addr_seen=0, all counters=0, and the tx shift register=0.
REQ-025 Reset asserted mid-frame SHALL discard the frame, and the first edge after release SHALL evaluate from IDLE.

Configuration
REQ-026 The macro SPI_FRAME_ERR_EN, when defined, SHALL add the output port frame_err  output  1, registered.
REQ-027 With SPI_FRAME_ERR_EN defined, frame_err SHALL pulse for one cycle when SS_n=1 is seen in WRITE/READ_ADD/READ_DATA before rx_valid was issued.
REQ-028 With SPI_FRAME_ERR_EN defined, frame_err SHALL also pulse for one cycle when SS_n=1 is seen in READ_DATA after tx_data was latched but before all 8 MISO bits were sent.
REQ-029 With SPI_FRAME_ERR_EN defined, frame_err SHALL reset to 0.
REQ-030 Without SPI_FRAME_ERR_EN, the frame_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 The package spi_pkg SHALL hold: the state enum typedef, FRAME_W=10, DATA_W=8, and the command encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10 and CMD_RD_DATA=2'b11.
REQ-032 The MISO serializer (latch, 8-bit shift, done flag) SHALL be the single sub-module spi_tx_ser; all other logic lives in spi_slave.

Verification
REQ-033 Write-address frame: SS_n low, MOSI bits 00_1010_0101 -> rx_valid one cycle at edge 11 with rx_data=10'h0A5; MISO stays 0.
REQ-034 Write-data frame: bits 01_0011_1100 -> rx_data=10'h13C; rd_addr_seen stays 0.
REQ-035 Read sequence, part 1: bits 10_0000_0111 -> rx_data=10'h207 and rd_addr_seen=1.
REQ-036 Read sequence, part 2: the next frame 11_xxxx_xxxx with tx_valid and tx_data=8'hC3 two edges later -> MISO shows 1,1,0,0,0,0,1,1 over 8 edges; rd_addr_seen=0 afterwards.
REQ-037 Abort: SS_n rises after 5 bits of a write frame -> no rx_valid, state returns to IDLE; frame_err pulses when SPI_FRAME_ERR_EN is defined.
REQ-038 Async reset: rst asserted mid-READ_DATA shift between clock edges -> MISO=0, rx_valid=0 and state=IDLE immediately; the next full write frame 00_1111_0000 gives rx_data=10'h0F0.
